// File: rtl/mmu_loader.sv
// mmu_loader: host byte-stream loader and 2x2 MMU pass sequencer.
// Loads four weight bytes and then four input bytes. It holds them stable on
// weight_*/input_* and drives en/mmu_cycles through a six-cycle feeder pass.
// Optional feature macro: MMU_LOADER_WEIGHT_REUSE_EN. When it is defined, a
// load may keep the stored weights and send only the four input bytes.
module mmu_loader (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       keep_weights,
    output logic       in_ready,
    output logic [7:0] weight_0,
    output logic [7:0] weight_1,
    output logic [7:0] weight_2,
    output logic [7:0] weight_3,
    output logic [7:0] input_0,
    output logic [7:0] input_1,
    output logic [7:0] input_2,
    output logic [7:0] input_3,
    output logic       en,
    output logic [2:0] mmu_cycles,
    output logic       done
);

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned N_ELEM  = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned CYC_W   = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(5);

    typedef enum logic [1:0] {
        LOAD_W = 2'd0,
        LOAD_I = 2'd1,
        RUN    = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                weights_valid_q, weights_valid_d;
    logic [DATA_W-1:0]   weight_q [N_ELEM];
    logic [DATA_W-1:0]   weight_d [N_ELEM];
    logic [DATA_W-1:0]   input_q  [N_ELEM];
    logic [DATA_W-1:0]   input_d  [N_ELEM];
    logic                en_q, en_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic                accept_c;

    // A byte transfers only when the registered ready is high.
    assign accept_c = in_valid && ready_q;

`ifndef MMU_LOADER_WEIGHT_REUSE_EN
    // keep_weights has no function in this build.
    logic unused_keep_weights;
    assign unused_keep_weights = keep_weights;
`endif

    // Next-state and next-output computation for the load/run sequencer.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        weights_valid_d = weights_valid_q;
        weight_d        = weight_q;
        input_d         = input_q;
        en_d            = en_q;
        cyc_d           = cyc_q;
        done_d          = 1'b0;
        ready_d         = ready_q;

        case (state_q)
            LOAD_W: begin
                ready_d = 1'b1;
                if (accept_c) begin
`ifdef MMU_LOADER_WEIGHT_REUSE_EN
                    if ((idx_q == '0) && weights_valid_q && keep_weights) begin
                        // The first byte is already an input, so skip the weight load.
                        input_d[0] = in_data;
                        idx_d      = IDX_W'(1);
                        state_d    = LOAD_I;
                    end else
`endif
                    begin
                        weight_d[idx_q] = in_data;
                        idx_d           = idx_q + IDX_W'(1);
                        if (idx_q == LAST_IDX) begin
                            weights_valid_d = 1'b1;
                            state_d         = LOAD_I;
                        end
                    end
                end
            end

            LOAD_I: begin
                ready_d = 1'b1;
                if (accept_c) begin
                    input_d[idx_q] = in_data;
                    idx_d          = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = RUN;
                        en_d    = 1'b1;
                        cyc_d   = '0;
                        ready_d = 1'b0;
                    end
                end
            end

            RUN: begin
                ready_d = 1'b0;
                if (cyc_q == LAST_CYC) begin
                    state_d = LOAD_W;
                    idx_d   = '0;
                    en_d    = 1'b0;
                    cyc_d   = '0;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end

            default: begin
                state_d = LOAD_W;
                idx_d   = '0;
                en_d    = 1'b0;
                cyc_d   = '0;
            end
        endcase
    end

    // State and output registers; reset discards any partial load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= LOAD_W;
            idx_q           <= '0;
            weights_valid_q <= 1'b0;
            en_q            <= 1'b0;
            cyc_q           <= '0;
            done_q          <= 1'b0;
            ready_q         <= 1'b0;
            for (int i = 0; i < N_ELEM; i++) begin
                weight_q[i] <= '0;
                input_q[i]  <= '0;
            end
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            weights_valid_q <= weights_valid_d;
            en_q            <= en_d;
            cyc_q           <= cyc_d;
            done_q          <= done_d;
            ready_q         <= ready_d;
            for (int i = 0; i < N_ELEM; i++) begin
                weight_q[i] <= weight_d[i];
                input_q[i]  <= input_d[i];
            end
        end
    end

    assign in_ready   = ready_q;
    assign weight_0   = weight_q[0];
    assign weight_1   = weight_q[1];
    assign weight_2   = weight_q[2];
    assign weight_3   = weight_q[3];
    assign input_0    = input_q[0];
    assign input_1    = input_q[1];
    assign input_2    = input_q[2];
    assign input_3    = input_q[3];
    assign en         = en_q;
    assign mmu_cycles = cyc_q;
    assign done       = done_q;

endmodule
